// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter_pkg                                                  |
// | Shared arbiter state encoding and the round-robin pick helper.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_tx_arbiter_pkg;

  localparam int c_RR_MAX = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Returns {found, index}: rotate so ptr is bit 0, find first, unrotate.
  function automatic logic [4:0] rr_pick(input logic [15:0] req,
                                         input logic [3:0]  ptr,
                                         input int          n);
    logic [15:0] rot;
    logic [4:0]  idx;
    logic [4:0]  pos;
    logic [3:0]  off;
    logic        found;
    rot   = '0;
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < c_RR_MAX; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'(n)) idx = idx - 5'(n);
      if (k < n) rot[k] = req[idx[3:0]];
    end
    for (int k = c_RR_MAX - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = 4'(k);
      end
    end
    pos = {1'b0, ptr} + {1'b0, off};
    if (pos >= 5'(n)) pos = pos - 5'(n);
    return {found, pos[3:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter_if                                                   |
// | Requester-side and UART-side handshake bundle for the arbiter.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int DI_WIDTH = 8
) ();
  logic [N_REQ*DI_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]          req_vld;
  logic [N_REQ-1:0]          req_last;
  logic [N_REQ-1:0]          req_rdy;
  logic [DI_WIDTH-1:0]       uart_din;
  logic                      uart_din_vld;
  logic                      uart_rfd;
  logic [N_REQ-1:0]          grant;
  logic                      busy;

  modport master (
    output req_data, req_vld, req_last, uart_rfd,
    input  req_rdy, uart_din, uart_din_vld, grant, busy
  );

  modport slave (
    input  req_data, req_vld, req_last, uart_rfd,
    output req_rdy, uart_din, uart_din_vld, grant, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick_onehot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick_onehot                                                       |
// | Combinational round-robin selector, one-hot result.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick_onehot
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant
);
  localparam int c_PW = $clog2(N);

  logic [15:0] w_req;
  logic [3:0]  w_ptr;
  logic [4:0]  w_pick;

  always_comb begin
    w_req            = '0;
    w_req[N-1:0]     = i_req;
    w_ptr            = '0;
    w_ptr[c_PW-1:0]  = i_ptr;
  end

  assign w_pick = rr_pick(w_req, w_ptr, N);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign o_grant[gi] = w_pick[4] && (w_pick[3:0] == 4'(gi));
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter                                                      |
// | Packet-level round-robin arbiter sharing one UART transmitter.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DI_WIDTH  = 8,
  parameter int BURST_MAX = 16,
  parameter int IDLE_TO   = 2048
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int c_PTR_W = $clog2(N_REQ);
  localparam int c_BC_W  = $clog2(BURST_MAX + 1);
  localparam int c_IC_W  = $clog2(IDLE_TO);
  localparam logic [c_BC_W-1:0] c_BURST_LAST = c_BC_W'(BURST_MAX - 1);
  localparam logic [c_IC_W-1:0] c_IDLE_LAST  = c_IC_W'(IDLE_TO - 1);

  arb_state_t          r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [c_PTR_W-1:0]  r_rr_ptr;
  logic [c_BC_W-1:0]   r_byte_cnt;
  logic [c_IC_W-1:0]   r_idle_cnt;

  logic [N_REQ-1:0]    w_pick;
  logic [c_PTR_W-1:0]  w_owner;
  logic [c_PTR_W-1:0]  w_next_ptr;
  logic                w_busy;
  logic                w_own_vld;
  logic                w_own_last;
  logic                w_xfer;
  logic                w_release;

  rr_pick_onehot #(.N(N_REQ)) u_pick (
    .i_req   (bus.req_vld),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick)
  );

  always_comb begin
    w_owner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) w_owner = c_PTR_W'(i);
    end
  end

  assign w_busy     = (r_state == OWN);
  assign w_own_vld  = w_busy && bus.req_vld[w_owner];
  assign w_own_last = bus.req_last[w_owner];
  assign w_xfer     = w_own_vld && bus.uart_rfd;
  // Last and burst-limit on the same transfer collapse into one release.
  assign w_release  = w_busy &&
                      ((w_xfer && (w_own_last || (r_byte_cnt == c_BURST_LAST))) ||
                       (!w_own_vld && (r_idle_cnt == c_IDLE_LAST)));
  assign w_next_ptr = (w_owner == c_PTR_W'(N_REQ - 1)) ? '0 : w_owner + c_PTR_W'(1);

  assign bus.uart_din     = w_busy ? bus.req_data[w_owner*DI_WIDTH +: DI_WIDTH] : '0;
  assign bus.uart_din_vld = w_own_vld;
  assign bus.req_rdy      = r_grant & {N_REQ{bus.uart_rfd}};
  assign bus.grant        = r_grant;
  assign bus.busy         = w_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_byte_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req_vld) begin
            r_grant    <= w_pick;
            r_byte_cnt <= '0;
            r_idle_cnt <= '0;
            r_state    <= OWN;
          end
        end
        OWN: begin
          if (w_xfer) r_byte_cnt <= r_byte_cnt + c_BC_W'(1);
          r_idle_cnt <= w_own_vld ? '0 : r_idle_cnt + c_IC_W'(1);
          if (w_release) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter                                                   |
// | Directed bench with a cycle-level reference model of the arbiter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int BURST = 4;
  localparam int IDLE  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.N_REQ(N), .DI_WIDTH(W)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N), .DI_WIDTH(W), .BURST_MAX(BURST), .IDLE_TO(IDLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Per-requester packet queues: {last, byte}
  logic [8:0]   q [N][$];
  logic [N-1:0] en = '1;
  int           rfd_mode = 0;
  logic [11:0]  log_q[$];
  int           stamp_q[$];
  logic [11:0]  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last);
    q[r].push_back({last, d});
  endtask

  task automatic ex(input int r, input logic [7:0] d);
    exp_q.push_back({4'(r), d});
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string name, input int max);
    bit done = 1'b0;
    for (int n = 0; n < max && !done; n++) begin
      @(posedge clk); #1;
      done = all_empty() && !bus.busy;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", name, i),
          32'((i < log_q.size()) ? log_q[i] : 12'hfff), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
    stamp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Requester and UART-side driver; records every transfer it sees.
  initial begin : p_drv
    logic [N-1:0] xf;
    int pc;
    pc = 0;
    bus.req_vld  = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.uart_rfd = 1'b0;
    forever begin
      @(negedge clk);
      xf = bus.req_vld & bus.req_rdy;
      for (int i = 0; i < N; i++) begin
        if (xf[i]) begin
          log_q.push_back({4'(i), bus.req_data[i*W +: W]});
          stamp_q.push_back(cyc);
        end
      end
      @(posedge clk); #2;
      pc++;
      for (int i = 0; i < N; i++) begin
        if (xf[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (en[i] && q[i].size() > 0) begin
          bus.req_vld[i]          = 1'b1;
          bus.req_last[i]         = q[i][0][8];
          bus.req_data[i*W +: W]  = q[i][0][7:0];
        end else begin
          bus.req_vld[i]  = 1'b0;
          bus.req_last[i] = 1'b0;
        end
      end
      bus.uart_rfd = (rfd_mode == 0) ? 1'b1 : (rfd_mode == 1) ? (pc % 10 == 0) : 1'b0;
    end
  end

  // Reference model: owner (-1 when idle), next search start, bytes moved
  // this grant, and consecutive cycles the owner has shown no data.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_bytes = 0;
  int m_idle  = 0;

  initial begin : p_model
    logic [N-1:0] e_grant, e_rdy;
    logic [W-1:0] e_din;
    logic         e_vld, v, rel;
    int           g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_owner = -1; m_ptr = 0; m_bytes = 0; m_idle = 0;
      end
      e_grant = '0; e_rdy = '0; e_din = '0; e_vld = 1'b0;
      if (m_owner >= 0) begin
        e_grant[m_owner] = 1'b1;
        e_vld = bus.req_vld[m_owner];
        e_din = bus.req_data[m_owner*W +: W];
        e_rdy[m_owner] = bus.uart_rfd;
      end
      chk("grant",    32'(bus.grant),        32'(e_grant));
      chk("busy",     32'(bus.busy),         32'(m_owner >= 0));
      chk("req_rdy",  32'(bus.req_rdy),      32'(e_rdy));
      chk("din_vld",  32'(bus.uart_din_vld), 32'(e_vld));
      chk("din",      32'(bus.uart_din),     32'(e_din));
      if (rst) begin
        if (m_owner < 0) begin
          for (int k = 0; k < N; k++)
            if (m_owner < 0 && bus.req_vld[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          m_bytes = 0;
          m_idle  = 0;
        end else begin
          g   = m_owner;
          v   = bus.req_vld[g];
          rel = 1'b0;
          if (v && bus.uart_rfd) begin
            m_bytes++;
            if (bus.req_last[g] || m_bytes == BURST) rel = 1'b1;
          end
          if (v) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == IDLE) rel = 1'b1;
          end
          if (rel) begin
            m_ptr   = (g + 1) % N;
            m_owner = -1;
          end
        end
      end
    end
  end

  initial begin : p_test
    int  dropc, relc, bad;
    bit  seen;

    // Reset state
    @(posedge clk); #3;
    chk("rst_grant",   32'(bus.grant),        32'h0);
    chk("rst_busy",    32'(bus.busy),         32'h0);
    chk("rst_din_vld", 32'(bus.uart_din_vld), 32'h0);
    chk("rst_din",     32'(bus.uart_din),     32'h0);
    chk("rst_ptr",     32'(dut.r_rr_ptr),     32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Single 3-byte packet, slow UART
    rfd_mode = 1;
    @(posedge clk); #1;
    push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    @(posedge clk); #3;
    chk("t1_grant", 32'(bus.grant), 32'h1);
    wait_idle("t1", 200);
    ex(0, 8'hA1); ex(0, 8'hA2); ex(0, 8'hA3);
    check_log("t1");
    chk("t1_ptr", 32'(dut.r_rr_ptr), 32'h1);

    // Four requesters, 1-byte packets, from reset
    do_reset();
    rfd_mode = 0;
    @(posedge clk); #1;
    push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    wait_idle("t2", 100);
    chk("t2_nstamp", 32'(stamp_q.size()), 32'd5);
    for (int i = 1; i < stamp_q.size(); i++)
      chk($sformatf("t2_gap%0d", i), 32'(stamp_q[i] - stamp_q[i-1]), 32'd2);
    ex(0, 8'h10); ex(1, 8'h11); ex(2, 8'h12); ex(3, 8'h13); ex(0, 8'h14);
    check_log("t2");

    // Burst limit: req 2 streams 10 bytes, req 0 waits
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) push(2, 8'(8'h20 + i), 1'b0);
    push(0, 8'h0F, 1'b1);
    wait_idle("t3", 200);
    for (int i = 0; i < 4; i++) ex(2, 8'(8'h20 + i));
    ex(0, 8'h0F);
    for (int i = 4; i < 10; i++) ex(2, 8'(8'h20 + i));
    check_log("t3");
    chk("t3_ptr", 32'(dut.r_rr_ptr), 32'h3);

    // Idle timeout on requester 1
    rfd_mode = 2;
    @(posedge clk); #1;
    push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      seen = (bus.grant == 4'b0010);
    end
    chk("t4_grant1", 32'(seen), 32'd1);
    push(3, 8'h33, 1'b1);
    @(posedge clk); #1;
    en[1] = 1'b0;
    dropc = cyc;
    relc  = -1;
    for (int n = 0; n < 30 && relc < 0; n++) begin
      @(negedge clk);
      if (!bus.busy) relc = cyc;
    end
    chk("t4_release_cycle", 32'(relc), 32'(dropc + 8));
    @(negedge clk);
    chk("t4_next_grant", 32'(bus.grant), 32'h8);
    @(posedge clk); #1;
    en[1]    = 1'b1;
    rfd_mode = 0;
    wait_idle("t4", 100);
    ex(3, 8'h33); ex(1, 8'h31); ex(1, 8'h32);
    check_log("t4");

    // Reset mid-packet after 2 of 5 bytes
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push(1, 8'(8'h51 + i), (i == 4));
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(posedge clk); #1;
      seen = (log_q.size() >= 2);
    end
    chk("t5_two_bytes", 32'(log_q.size()), 32'd2);
    rst = 1'b0;
    push(3, 8'h5F, 1'b1);
    #2;
    chk("t5_grant",   32'(bus.grant),        32'h0);
    chk("t5_busy",    32'(bus.busy),         32'h0);
    chk("t5_rdy",     32'(bus.req_rdy),      32'h0);
    chk("t5_din_vld", 32'(bus.uart_din_vld), 32'h0);
    chk("t5_din",     32'(bus.uart_din),     32'h0);
    chk("t5_ptr",     32'(dut.r_rr_ptr),     32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_idle("t5", 100);
    for (int i = 0; i < 5; i++) ex(1, 8'(8'h51 + i));
    ex(3, 8'h5F);
    check_log("t5");

    // UART not ready for 50 cycles: owner holds, no release
    rfd_mode = 2;
    @(posedge clk); #1;
    push(0, 8'h61, 1'b1);
    @(posedge clk);
    bad = 0;
    repeat (50) begin
      @(posedge clk); #3;
      if (bus.req_rdy != '0 || bus.uart_din != 8'h61 || !bus.busy || bus.grant != 4'b0001)
        bad++;
    end
    chk("t6_hold", 32'(bad), 32'd0);
    rfd_mode = 0;
    wait_idle("t6", 50);
    ex(0, 8'h61);
    check_log("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares one UART transmitter between `N_REQ` byte-stream requesters. It sits directly in front of the `UART` top's `din`/`din_vld`/`rfd` interface. It locks the transmitter to one requester for a whole packet, bounded by a burst limit and an idle timeout, so that packets from different sources never interleave on `tx`.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `DI_WIDTH`, 8, byte width; must equal `UART.DI_WIDTH`
- `BURST_MAX`, 16, maximum bytes per grant before forced release (≥1)
- `IDLE_TO`, 2048, clk cycles a granted requester may leave `req_vld` low before forced release (≥2)

Ports:
- `clk` in 1, system clock (same as `UART`)
- `rst` in 1, asynchronous active-low reset
- `req_data` in N_REQ*DI_WIDTH, requester i byte at `[i*DI_WIDTH +: DI_WIDTH]`
- `req_vld` in N_REQ, per-requester byte valid
- `req_last` in N_REQ, per-requester last byte of packet (qualified by `req_vld`)
- `req_rdy` out N_REQ, per-requester accept
- `uart_din` out DI_WIDTH, to `UART.din`
- `uart_din_vld` out 1, to `UART.din_vld`
- `uart_rfd` in 1, from `UART.rfd`
- `grant` out N_REQ, one-hot current owner; all-zero when idle
- `busy` out 1, high while a grant is held

## Operation
- Transfer on requester g: `req_vld[g] && req_rdy[g]` in the same cycle, which is equivalent to `uart_din_vld && uart_rfd`.
- State `IDLE`:
  - `grant`=0, all `req_rdy`=0, `uart_din_vld`=0.
  - If any `req_vld` is high, select the first set bit searching upward from `rr_ptr` with wrap.
  - Register the selection into `grant`, clear `byte_cnt` and `idle_cnt`, and go to `OWN`.
- State `OWN` (owner g), combinational pass-through:
  - `uart_din = req_data[g]`, `uart_din_vld = req_vld[g]`, `req_rdy[g] = uart_rfd`; all other `req_rdy` = 0.
  - `byte_cnt` increments on each transfer and is $clog2(BURST_MAX+1) bits wide. It saturates only through the release rule.
  - `idle_cnt` increments each cycle `req_vld[g]`=0 and clears on each cycle `req_vld[g]`=1.
- Release from `OWN` to `IDLE` on the clock edge after any of these:
  - a transfer with `req_last[g]`=1;
  - a transfer where `byte_cnt == BURST_MAX-1`;
  - `idle_cnt == IDLE_TO-1` with `req_vld[g]`=0.
- On release, `rr_ptr <= (g+1) mod N_REQ` and `grant <= 0`.
- A forced release (burst or timeout) does not drop bytes. The requester keeps `req_vld` asserted and resumes on its next grant.
- Requester-side rules:
  - `req_data` and `req_last` must be stable while `req_vld` is high and `req_rdy` is low.
  - Deasserting `req_vld` without a transfer is permitted. It only advances the idle timeout.
- Reset behaviour: `rst` low at any time immediately forces `IDLE`, with `grant`=0, `busy`=0, `req_rdy`=0, `uart_din_vld`=0, `uart_din`=0, `rr_ptr`=0, `byte_cnt`=0, `idle_cnt`=0. A byte already latched by `UART_TX` is not the arbiter's concern.

## Timing
- Arbitration latency: `req_vld` rising in `IDLE` at cycle t gives `grant`/`busy` high at t+1. The first transfer is possible at t+1 if `uart_rfd`=1.
- Each grant costs exactly one `IDLE` cycle, so back-to-back packets from different requesters have one dead cycle between them.
- Output paths:
  - `uart_din`, `uart_din_vld` and `req_rdy` are combinational from registered `grant` and the inputs.
  - There is no path from `uart_rfd` to `grant`.
- Simultaneous events:
  - A transfer with `req_last` in the same cycle that `idle_cnt` would time out cannot occur, because `req_vld` is high. Last and burst in the same transfer cause a single release.
  - A new `req_vld` from another requester during `OWN` is ignored until release.
- Wrap-around: `rr_ptr` = N_REQ-1 followed by a release goes to 0.

## Structure
- Shared package holds the state encoding (`IDLE`, `OWN`) and a `rr_pick` function (rotate, priority-find-first, unrotate) reused by future multi-master blocks.
- One sub-module is natural: `rr_pick_onehot` (combinational, parameter N), which instantiates the function. Everything else stays in the top.

## Test plan
- Single requester, 3-byte packet 0xA1,0xA2,0xA3 (last on 0xA3), `uart_rfd` pulsing 1 cycle in 10 → three transfers in order; `grant` = 0001 from t+1 until the cycle after 0xA3; `rr_ptr`=1.
- All four requesters hold 1-byte packets from reset → grant order 0,1,2,3,0, each grant one cycle after the previous release.
- `BURST_MAX`=4, requester 2 streams 10 bytes with no `req_last`, requester 0 waiting → 4 bytes from req 2, then req 0's packet, then req 2 resumes at byte 5 with no byte lost.
- `IDLE_TO`=8, requester 1 granted then drops `req_vld` → release exactly 8 cycles after the drop; the next requester is granted one cycle later.
- Reset pulse mid-packet (after 2 of 5 bytes) → all outputs 0 within the same cycle; after reset, the arbiter restarts from `rr_ptr`=0.
- Requester holds `req_vld` with `uart_rfd`=0 for 50 cycles → `req_rdy`=0 throughout, `uart_din` stable, no release (the idle timeout does not advance).
